// File: rtl/prefix_add_sequencer_pkg.sv
// Shared definitions for the time-shared prefix add/subtract sequencer.
// Holds the default geometry, the derived operand width, the chunk-counter
// width and the sequencer state encoding.
package prefix_add_sequencer_pkg;

  // Counter width that stays legal when only one chunk is configured.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_CHUNK_W = 12;
  localparam int unsigned DEF_NCHUNK  = 4;
  localparam int unsigned DEF_OP_W    = DEF_CHUNK_W * DEF_NCHUNK;
  localparam int unsigned DEF_CNT_W   = cnt_width(DEF_NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prefix_add_sequencer_chunk.sv
// prefix_chunk_add: combinational W-bit Kogge-Stone adder with carry-in.
// Ports:
//   a, b   in  W  chunk operands
//   cin    in  1  carry into bit 0
//   sum    out W  a + b + cin (mod 2^W)
//   cout   out 1  carry out of bit W-1
//   c_msb  out 1  carry into bit W-1 (for signed overflow detection)
module prefix_chunk_add #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  // Bit 0 of the extended vector is a pseudo-bit carrying cin as a pure
  // generate, so group G at extended index j is the carry into operand bit j.
  localparam int N      = int'(W) + 1;
  localparam int LEVELS = $clog2(N);

  logic [N-1:0] g_in;
  logic [N-1:0] p_in;
  logic [N-1:0] grp_g;

  assign g_in = {a & b, cin};
  assign p_in = {a ^ b, 1'b0};

  // Log2-depth prefix tree; each level combines spans twice as wide.
  always_comb begin : ks_tree
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] g_nx;
    logic [N-1:0] p_nx;
    g    = g_in;
    p    = p_in;
    g_nx = g_in;
    p_nx = p_in;
    for (int l = 0; l < LEVELS; l++) begin
      g_nx = g;
      p_nx = p;
      for (int i = (1 << l); i < N; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_nx[i] = p[i] & p[i - (1 << l)];
      end
      g = g_nx;
      p = p_nx;
    end
    grp_g = g;
  end

  assign sum   = p_in[N-1:1] ^ grp_g[N-2:0];
  assign cout  = grp_g[N-1];
  assign c_msb = grp_g[N-2];

endmodule

// File: rtl/prefix_add_sequencer.sv
// prefix_add_sequencer: shares one CHUNK_W-bit prefix adder between two
// requesters, performing an OP_W-bit add/subtract one chunk per cycle,
// LSB chunk first, with the carry chained between chunks.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req_valid   in  2       request valid per requester
//   req_ready   out 2       request accepted (combinational grant, IDLE only)
//   req_a/req_b in  2*OP_W  operands, requester i at [i*OP_W +: OP_W]
//   req_sub     in  2       1 = A-B, 0 = A+B
//   rsp_valid   out 1       result valid (held until rsp_ready)
//   rsp_ready   in  1       consumer accepts result
//   rsp_id      out 1       requester index of the result
//   rsp_sum     out OP_W    result modulo 2^OP_W
//   rsp_cout    out 1       carry out of MSB (subtract: 1 = no borrow)
//   rsp_ovf     out 1       signed overflow
//   busy        out 1       operation in progress or awaiting handshake
module prefix_add_sequencer
  import prefix_add_sequencer_pkg::*;
#(
  parameter  int unsigned CHUNK_W = DEF_CHUNK_W,
  parameter  int unsigned NCHUNK  = DEF_NCHUNK,
  localparam int unsigned OP_W    = CHUNK_W * NCHUNK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_a,
  input  logic [2*OP_W-1:0] req_b,
  input  logic [1:0]        req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [OP_W-1:0]   rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              busy
);

  localparam int unsigned    CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NCHUNK - 1);

  state_e            state;
  state_e            state_nxt;

  logic              rr;
  logic [1:0]        grant;
  logic              accept;
  logic              acc_id;
  logic [OP_W-1:0]   sel_a;
  logic [OP_W-1:0]   sel_b;
  logic              sel_sub;

  logic [CNT_W-1:0]  k;
  logic              carry;
  logic              id_q;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [OP_W-1:0]   result;
  logic              cout_q;
  logic              ovf_q;

  logic [CHUNK_W-1:0] chunk_a;
  logic [CHUNK_W-1:0] chunk_b;
  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_cout;
  logic               chunk_cmsb;
  logic               last_chunk;

  // Round-robin grant: requester at rr has priority, the other is fallback.
  always_comb begin
    grant = 2'b00;
    if (req_valid[rr]) begin
      grant[rr] = 1'b1;
    end else if (req_valid[~rr]) begin
      grant[~rr] = 1'b1;
    end
  end

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = req_ready[1];

  // Operand mux for the winning requester; B is pre-inverted for subtract.
  always_comb begin
    sel_a   = req_a[OP_W-1:0];
    sel_b   = req_b[OP_W-1:0];
    sel_sub = req_sub[0];
    if (acc_id) begin
      sel_a   = req_a[2*OP_W-1:OP_W];
      sel_b   = req_b[2*OP_W-1:OP_W];
      sel_sub = req_sub[1];
    end
    if (sel_sub) begin
      sel_b = ~sel_b;
    end
  end

  assign last_chunk = (k == LAST_K);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)     state_nxt = RUN;
      RUN:  if (last_chunk) state_nxt = DONE;
      DONE: if (rsp_ready)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Chunk k of the latched operands feeds the shared prefix stage.
  assign chunk_a = op_a[32'(k) * CHUNK_W +: CHUNK_W];
  assign chunk_b = op_b[32'(k) * CHUNK_W +: CHUNK_W];

  prefix_chunk_add #(
    .W (CHUNK_W)
  ) u_chunk (
    .a     (chunk_a),
    .b     (chunk_b),
    .cin   (carry),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  // Operand capture on accept, chunk-serial accumulation during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr     <= 1'b0;
      k      <= '0;
      carry  <= 1'b0;
      id_q   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        carry <= sel_sub;
        k     <= '0;
        id_q  <= acc_id;
        rr    <= ~acc_id;
      end
      if (state == RUN) begin
        result[32'(k) * CHUNK_W +: CHUNK_W] <= chunk_sum;
        carry <= chunk_cout;
        k     <= k + CNT_W'(1);
        // Flags come from the most significant chunk only.
        if (last_chunk) begin
          cout_q <= chunk_cout;
          ovf_q  <= chunk_cout ^ chunk_cmsb;
        end
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = result;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_prefix_add_sequencer.sv
// Self-checking bench for prefix_add_sequencer: directed cases, randomized
// operations against an arithmetic reference model, round-robin alternation,
// response backpressure and asynchronous reset during an operation.
module tb_prefix_add_sequencer;

  localparam int CW = 12;
  localparam int NC = 4;
  localparam int OW = CW * NC;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*OW-1:0]   req_a;
  logic [2*OW-1:0]   req_b;
  logic [1:0]        req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [OW-1:0]     rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic              busy;

  int total;
  int bad;

  prefix_add_sequencer #(
    .CHUNK_W (CW),
    .NCHUNK  (NC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [OW+1:0] ref_op(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                           input logic sub);
    longint sa, sb, r;
    longint max_s, min_s;
    logic [OW:0]   u;
    logic [OW-1:0] s;
    logic          c, o;
    max_s = (longint'(1) <<< (OW - 1)) - 1;
    min_s = -(longint'(1) <<< (OW - 1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      s = a - b;
      c = (a >= b);
      r = sa - sb;
    end else begin
      u = {1'b0, a} + {1'b0, b};
      s = u[OW-1:0];
      c = u[OW];
      r = sa + sb;
    end
    o = (r > max_s) || (r < min_s);
    return {o, c, s};
  endfunction

  function automatic logic [OW-1:0] rand_op();
    logic [63:0]   t;
    logic [OW-1:0] special [4];
    special[0] = '0;
    special[1] = '1;
    special[2] = {1'b0, {(OW-1){1'b1}}};
    special[3] = {1'b1, {(OW-1){1'b0}}};
    t = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 3)];
    return t[OW-1:0];
  endfunction

  // Drives one request and waits for its response (bounded); no checking.
  task automatic do_txn(input int idx, input logic [OW-1:0] a, input logic [OW-1:0] b,
                        input logic sub, output logic to, output int lat,
                        output logic [OW-1:0] s, output logic co, output logic ov,
                        output logic rid);
    int n;
    to = 1'b1; lat = 0; s = '0; co = 1'b0; ov = 1'b0; rid = 1'b0;
    @(negedge clk);
    req_a[idx*OW +: OW] = a;
    req_b[idx*OW +: OW] = b;
    req_sub[idx]        = sub;
    req_valid[idx]      = 1'b1;
    rsp_ready           = 1'b1;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready[idx]) begin
      req_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    if (rsp_valid) begin
      to = 1'b0; s = rsp_sum; co = rsp_cout; ov = rsp_ovf; rid = rsp_id;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_sub = 2'b00;
    repeat (2) @(negedge clk);
    total++;
    if ({rsp_valid, busy, rsp_id, rsp_cout, rsp_ovf} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {rsp_valid, busy, rsp_id, rsp_cout, rsp_ovf});
    end
    total++;
    if (rsp_sum !== '0) begin
      bad++; $display("FAIL reset_sum got=%h exp=0", rsp_sum);
    end
    req_valid = 2'b11; #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL reset_ready_both got=%b exp=01", req_ready);
    end
    req_valid = 2'b10; #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++; $display("FAIL reset_ready_one got=%b exp=10", req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int            d_idx [4];
    logic [OW-1:0] d_a [4], d_b [4], e_sum [4];
    logic          d_sub [4], e_co [4], e_ov [4];
    logic          to, co, ov, rid;
    int            lat;
    logic [OW-1:0] s;
    d_idx = '{0, 1, 0, 0};
    d_a   = '{48'h000000000FFF, 48'hFFFFFFFFFFFF, 48'd5, 48'h7FFFFFFFFFFF};
    d_b   = '{48'h1, 48'h1, 48'd7, 48'h1};
    d_sub = '{1'b0, 1'b0, 1'b1, 1'b0};
    e_sum = '{48'h000000001000, 48'h000000000000, 48'hFFFFFFFFFFFE, 48'h800000000000};
    e_co  = '{1'b0, 1'b1, 1'b0, 1'b0};
    e_ov  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 4; t++) begin
      do_txn(d_idx[t], d_a[t], d_b[t], d_sub[t], to, lat, s, co, ov, rid);
      total++;
      if (to !== 1'b0) begin
        bad++; $display("FAIL dir%0d_timeout got=%b exp=0", t, to);
      end
      total++;
      if (lat != NC) begin
        bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", t, lat, NC);
      end
      total++;
      if ({s, co, ov, rid} !== {e_sum[t], e_co[t], e_ov[t], 1'(d_idx[t])}) begin
        bad++;
        $display("FAIL dir%0d_result got=%h/%b/%b/%b exp=%h/%b/%b/%b", t, s, co, ov, rid,
                 e_sum[t], e_co[t], e_ov[t], 1'(d_idx[t]));
      end
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] a, b, s;
    logic [OW+1:0] e;
    logic          sub, to, co, ov, rid;
    int            idx, lat;
    for (int t = 0; t < 24; t++) begin
      idx = int'($urandom_range(0, 1));
      a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
      e = ref_op(a, b, sub);
      do_txn(idx, a, b, sub, to, lat, s, co, ov, rid);
      total++;
      if (to !== 1'b0 || lat != NC) begin
        bad++; $display("FAIL rnd%0d_timing got=to%b/lat%0d exp=to0/lat%0d", t, to, lat, NC);
      end
      total++;
      if ({ov, co, s} !== e || rid !== 1'(idx)) begin
        bad++;
        $display("FAIL rnd%0d_result a=%h b=%h sub=%b got=%h/%b/%b/id%b exp=%h/%b/%b/id%b", t, a, b,
                 sub, s, co, ov, rid, e[OW-1:0], e[OW], e[OW+1], 1'(idx));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] ta [2], tb [2];
    logic          ts [2];
    logic [OW+1:0] e;
    int            g_id [$];
    int            g_cyc [$];
    int            n;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ta[i] = rand_op(); tb[i] = rand_op(); ts[i] = 1'($urandom_range(0, 1));
      req_a[i*OW +: OW] = ta[i]; req_b[i*OW +: OW] = tb[i]; req_sub[i] = ts[i];
    end
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      #1;
      total++;
      if (!$onehot0(req_ready) || (busy && req_ready != 2'b00)) begin
        bad++; $display("FAIL b2b_ready_c%0d got=%b busy=%b exp=onehot0_idle_only", c, req_ready, busy);
      end
      if (req_ready != 2'b00) begin
        g_id.push_back(int'(req_ready[1])); g_cyc.push_back(c);
      end
      if (rsp_valid) begin
        e = ref_op(ta[rsp_id], tb[rsp_id], ts[rsp_id]);
        total++;
        if ({rsp_ovf, rsp_cout, rsp_sum} !== e) begin
          bad++; $display("FAIL b2b_rsp_c%0d id=%b got=%h exp=%h", c, rsp_id, {rsp_ovf, rsp_cout, rsp_sum}, e);
        end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    total++;
    if (g_id.size() < 4) begin
      bad++; $display("FAIL b2b_grant_count got=%0d exp>=4", g_id.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (g_id[i] != (i % 2)) begin
          bad++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", i, g_id[i], i % 2);
        end
        if (i > 0) begin
          total++;
          if (g_cyc[i] - g_cyc[i-1] != NC + 2) begin
            bad++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, g_cyc[i] - g_cyc[i-1], NC + 2);
          end
        end
      end
    end
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk); n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got=%b exp=0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] a0, b0, a1, b1, c_sum;
    logic          s0, s1, c_co, c_ov, c_id;
    logic [OW+1:0] e;
    int            n;
    a0 = rand_op(); b0 = rand_op(); s0 = 1'($urandom_range(0, 1));
    a1 = rand_op(); b1 = rand_op(); s1 = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_a[OW-1:0] = a0; req_b[OW-1:0] = b0; req_sub[0] = s0;
    req_valid = 2'b01; rsp_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL bp_first_ready got=%b exp=01", req_ready);
    end
    @(negedge clk);
    req_a[2*OW-1:OW] = a1; req_b[2*OW-1:OW] = b1; req_sub[1] = s1;
    req_valid = 2'b10;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    c_sum = rsp_sum; c_co = rsp_cout; c_ov = rsp_ovf; c_id = rsp_id;
    e = ref_op(a0, b0, s0);
    total++;
    if (rsp_valid !== 1'b1 || {c_ov, c_co, c_sum} !== e || c_id !== 1'b0) begin
      bad++; $display("FAIL bp_result got=v%b/%h/id%b exp=v1/%h/id0", rsp_valid, {c_ov, c_co, c_sum}, c_id, e);
    end
    for (int h = 0; h < 5; h++) begin
      #1;
      total++;
      if ({rsp_sum, rsp_cout, rsp_ovf, rsp_id} !== {c_sum, c_co, c_ov, c_id} ||
          rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold%0d got=%h/%b/%b/%b v%b busy%b rdy%b exp=%h/%b/%b/%b v1 busy1 rdy00", h,
                 rsp_sum, rsp_cout, rsp_ovf, rsp_id, rsp_valid, busy, req_ready, c_sum, c_co, c_ov, c_id);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL bp_handshake_ready got=%b exp=00", req_ready);
    end
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10 || rsp_sum !== c_sum) begin
      bad++; $display("FAIL bp_after got=v%b rdy%b sum%h exp=v0 rdy10 sum%h", rsp_valid, req_ready, rsp_sum, c_sum);
    end
    @(negedge clk);
    req_valid = 2'b00;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL bp_second_accept got=%b exp=1", busy);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    e = ref_op(a1, b1, s1);
    total++;
    if (rsp_valid !== 1'b1 || {rsp_ovf, rsp_cout, rsp_sum} !== e || rsp_id !== 1'b1) begin
      bad++; $display("FAIL bp_second got=v%b/%h/id%b exp=v1/%h/id1", rsp_valid, {rsp_ovf, rsp_cout, rsp_sum}, rsp_id, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [OW-1:0] a, b, s;
    logic          sub, to, co, ov, rid;
    logic [OW+1:0] e;
    int            lat;
    @(negedge clk);
    req_a[OW-1:0] = rand_op(); req_b[OW-1:0] = rand_op(); req_sub[0] = 1'b0;
    req_valid = 2'b01; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy_before got=%b exp=1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, busy, rsp_id, rsp_cout, rsp_ovf} !== 5'b0 || rsp_sum !== '0) begin
      bad++;
      $display("FAIL mid_async_reset got=%b/%h exp=00000/0", {rsp_valid, busy, rsp_id, rsp_cout, rsp_ovf}, rsp_sum);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL mid_no_rsp got=%b exp=0", rsp_valid);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 2'b11; #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL mid_rr_cleared got=%b exp=01", req_ready);
    end
    req_valid = 2'b10; #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++; $display("FAIL mid_req1_ready got=%b exp=10", req_ready);
    end
    req_valid = 2'b00;
    a = rand_op(); b = rand_op(); sub = 1'b1;
    e = ref_op(a, b, sub);
    do_txn(1, a, b, sub, to, lat, s, co, ov, rid);
    total++;
    if (to !== 1'b0 || lat != NC || {ov, co, s} !== e || rid !== 1'b1) begin
      bad++;
      $display("FAIL mid_after got=to%b lat%0d %h id%b exp=to0 lat%0d %h id1", to, lat, {ov, co, s}, rid, NC, e);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
